imem_loader: RTL and testbench

Boot-time program loader for the single-cycle RISC-V core. It receives a length-prefixed, checksummed byte stream over a valid/ready interface and assembles the bytes into little-endian 32-bit words. It writes those words into the instruction memory's write port, which is the write side of the port the core fetches from. The core's reset is held until a load completes with a good checksum.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/word_packer.sv | 35 +++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// IMEM_ADDR_W is also the default width used by the instruction-memory model.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 10;

  // Byte lanes within a little-endian 32-bit word
  localparam int       LANE_W    = 8;
  localparam int       LANE3_LSB = 24;
  localparam logic [1:0] LAST_LANE = 2'd3;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// Collects stream bytes into little-endian 32-bit words.
// word_valid/word_out are combinational on the 4th byte so the caller can register them.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_valid
);

  logic [1:0]           cnt_q;
  logic [LANE3_LSB-1:0] lanes_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      lanes_q <= '0;
    end else if (clear) begin
      cnt_q   <= '0;
      lanes_q <= '0;
    end else if (byte_en) begin
      cnt_q   <= cnt_q + 2'd1;
      lanes_q <= {byte_in, lanes_q[LANE3_LSB-1:LANE_W]};
    end
  end

  // After three shifts the first byte of the word sits in the low lane
  assign word_out   = {byte_in, lanes_q};
  assign word_valid = byte_en && (cnt_q == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream, writes words
// into instruction memory, and releases the core reset only after a good load.
//
// state    | meaning
// S_LEN_LO | waiting for low byte of word count
// S_LEN_HI | waiting for high byte; validates count against capacity
// S_DATA   | packing data bytes, one write per 4 bytes
// S_CSUM   | waiting for checksum byte
// S_DONE   | load good, core released, stream blocked
// S_ERR    | load aborted, core held, stream blocked
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_rst_n,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] CAP = 17'd1 << (ADDR_W - 2);

  loader_state_t     state_q;
  logic [7:0]        len_lo_q;
  logic [ADDR_W-2:0] n_q;
  logic [ADDR_W-2:0] idx_q;
  logic [7:0]        acc_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              core_rst_n_q;
  logic              done_q;
  logic              err_q;

  logic        hs;
  logic [15:0] n_d;
  logic        byte_en;
  logic [31:0] word_out;
  logic        word_valid;

  assign hs      = in_valid & in_ready_q;
  assign n_d     = {in_data, len_lo_q};
  assign byte_en = hs && (state_q == S_DATA) && !restart;

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_LEN_LO;
      len_lo_q     <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else if (restart) begin
      // Memory contents and the last write bus values are left as they are
      state_q      <= S_LEN_LO;
      idx_q        <= '0;
      acc_q        <= '0;
      in_ready_q   <= 1'b1;
      wr_en_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        S_LEN_LO: begin
          in_ready_q <= 1'b1;
          if (hs) begin
            len_lo_q <= in_data;
            state_q  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (hs) begin
            if ({1'b0, n_d} > CAP) begin
              state_q    <= S_ERR;
              err_q      <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              n_q     <= n_d[ADDR_W-2:0];
              state_q <= (n_d == 16'd0) ? S_CSUM : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (hs) begin
            acc_q <= acc_q ^ in_data;
            if (word_valid) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= word_out;
              wr_addr_q <= {idx_q[ADDR_W-3:0], 2'b00};
              idx_q     <= idx_q + 1'b1;
              if (idx_q == n_q - 1'b1) state_q <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (hs) begin
            in_ready_q <= 1'b0;
            if (in_data == acc_q) begin
              state_q      <= S_DONE;
              done_q       <= 1'b1;
              core_rst_n_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: in_ready_q <= 1'b0;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_rst_n = core_rst_n_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams are scored by a byte-level model of the load format.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int CAP    = 1 << (ADDR_W - 2);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              restart = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_rst_n;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_errs   = 0;
  bit stalled  = 1'b0;

  logic [ADDR_W-1:0] got_a[$];
  logic [31:0]       got_d[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .restart    (restart),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_a.push_back(wr_addr);
      got_d.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    if (!stalled) begin
      ok = 1'b0;
      for (int k = 0; k < 64 && !ok; k++) begin
        @(negedge clk);
        if (in_ready === 1'b1) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("handshake", ok, 1'b1);
      if (!ok) stalled = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(posedge clk);
    #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    chk("rs_done", done, 1'b0);
    chk("rs_err", err, 1'b0);
    chk("rs_core_rst_n", core_rst_n, 1'b0);
    chk("rs_in_ready", in_ready, 1'b1);
  endtask

  // gap < 0 selects a random 0..3 cycle gap before every byte
  task automatic run_load(input string name, input logic [7:0] s[$], input int gap);
    int          n;
    int          consume;
    logic [7:0]  csum;
    logic [31:0] w;
    bit          exp_done;
    bit          exp_err;
    bit          busy;
    logic [ADDR_W-1:0] exp_a[$];
    logic [31:0]       exp_d[$];

    n = int'(s[0]) + 256 * int'(s[1]);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n > CAP) begin
      exp_err = 1'b1;
      consume = 2;
    end else begin
      csum = 8'h00;
      for (int i = 0; i < n; i++) begin
        w = '0;
        for (int j = 0; j < 4; j++) begin
          w    = w | (32'(s[2 + 4*i + j]) << (8*j));
          csum = csum ^ s[2 + 4*i + j];
        end
        exp_a.push_back(ADDR_W'(4 * i));
        exp_d.push_back(w);
      end
      consume  = 3 + 4*n;
      exp_done = (s[2 + 4*n] == csum);
      exp_err  = !exp_done;
    end

    got_a.delete();
    got_d.delete();
    for (int i = 0; i < consume; i++)
      send_byte(s[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    chk({name, "_wr_count"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk({name, "_wr_addr"}, got_a[i], exp_a[i]);
      chk({name, "_wr_data"}, got_d[i], exp_d[i]);
    end
    chk({name, "_done"}, done, exp_done);
    chk({name, "_err"}, err, exp_err);
    chk({name, "_core_rst_n"}, core_rst_n, exp_done);
    chk({name, "_in_ready"}, in_ready, 1'b0);

    // Bytes offered after the end of a load must not be taken
    in_valid = 1'b1;
    in_data  = 8'h5A;
    busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (in_ready !== 1'b0) busy = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({name, "_blocked"}, busy, 1'b0);
    chk({name, "_done_hold"}, done, exp_done);
    chk({name, "_no_late_wr"}, got_a.size(), exp_a.size());
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] x;
    int         n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_wr_data", wr_data, '0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_core_rst_n", core_rst_n, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_rise", in_ready, 1'b1);

    s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    run_load("single", s, 0);
    do_restart();
    s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC4};
    run_load("badsum", s, 0);
    do_restart();
    s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    run_load("two_stall", s, 3);
    do_restart();
    s = '{8'h00, 8'h00, 8'h00};
    run_load("zero_ok", s, 0);
    do_restart();
    s = '{8'h00, 8'h00, 8'h01};
    run_load("zero_bad", s, 0);
    do_restart();
    s = '{8'h01, 8'h01, 8'h00, 8'h00};
    run_load("oversize", s, 0);
    do_restart();

    // Exactly full memory
    s = '{8'h00, 8'h01};
    x = 8'h00;
    for (int i = 0; i < 4 * CAP; i++) begin
      s.push_back(8'($urandom));
      x = x ^ s[$];
    end
    s.push_back(x);
    run_load("full", s, 0);

    for (int t = 0; t < 12; t++) begin
      do_restart();
      if (t == 5) n = int'($urandom_range(CAP + 1, 65535));
      else        n = int'($urandom_range(0, 8));
      s = '{};
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      x = 8'h00;
      if (n <= CAP) begin
        for (int i = 0; i < 4 * n; i++) begin
          s.push_back(8'($urandom));
          x = x ^ s[$];
        end
        if ($urandom_range(0, 2) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
        s.push_back(x);
      end
      run_load("rand", s, -1);
    end

    do_restart();
    s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    run_load("pre_rst", s, 0);
    do_restart();

    // Asynchronous reset with half a word assembled
    got_a.delete();
    got_d.delete();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_wr_en", wr_en, 1'b0);
    chk("arst_wr_addr", wr_addr, '0);
    chk("arst_wr_data", wr_data, '0);
    chk("arst_done", done, 1'b0);
    chk("arst_err", err, 1'b0);
    chk("arst_core_rst_n", core_rst_n, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_wr", got_a.size(), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ready_rise", in_ready, 1'b1);

    s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    run_load("post_rst", s, -1);
    do_restart();
    run_load("reload", s, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
